// File: rtl/booth_mult_arbiter_pkg.sv
// booth_mult_arbiter_pkg: shared FSM encoding and default operand width
package booth_mult_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;
  localparam int DEF_WIDTH = 12;
endpackage

// File: rtl/booth_mult.sv
// booth_mult: combinational signed radix-4 Booth multiplier
module booth_mult #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] p
);
  logic [2*WIDTH-1:0] xe, pp, acc;
  logic [WIDTH:0]     ye;
  logic [2:0]         trip;
  assign xe = {{WIDTH{x[WIDTH-1]}}, x};
  assign ye = {y, 1'b0};
  always_comb begin
    acc  = '0;
    pp   = '0;
    trip = '0;
    for (int j = 0; j < WIDTH / 2; j++) begin
      trip = ye[2*j +: 3];
      pp   = (trip == 3'b001 || trip == 3'b010) ? xe :
             (trip == 3'b011) ? xe << 1 :
             (trip == 3'b100) ? -(xe << 1) :
             (trip == 3'b101 || trip == 3'b110) ? -xe : '0;
      acc  = acc + (pp << (2 * j));
    end
  end
  assign p = acc;
endmodule

// File: rtl/booth_mult_arbiter_rr_pick.sv
// rr_pick: round-robin picker, first set request at or above ptr modulo NREQ
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) idx = PW'(j);
    end
  end
  assign any = |req;
  assign gnt = any ? (NREQ'(1) << idx) : '0;
endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin shared, fully registered Booth multiplier
module booth_mult_arbiter
  import booth_mult_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 4,
  parameter int CNTW  = 16,
  parameter int PW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_p,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);
  state_t             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d, owner_q, owner_d, idx;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [2*WIDTH-1:0] p_q, p_d, prod;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]    gnt;
  logic               any, done;
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(req_valid), .ptr(rr_ptr_q), .gnt(gnt), .idx(idx), .any(any)
  );
  booth_mult #(.WIDTH(WIDTH)) u_mult (.x(x_q), .y(y_q), .p(prod));
  assign done = (state_q == RESP) && rsp_ready[owner_q];
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    x_d      = x_q;
    y_d      = y_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE && any) begin
      x_d     = req_x[idx*WIDTH +: WIDTH];
      y_d     = req_y[idx*WIDTH +: WIDTH];
      owner_d = idx;
      state_d = CALC;
    end
    if (state_q == CALC) begin
      p_d     = prod;
      state_d = RESP;
    end
    if (done) begin
      cnt_d    = &cnt_q ? cnt_q : cnt_q + 1'b1;
      rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      state_d  = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      x_q      <= x_d;
      y_q      <= y_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
    end
  end
  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign rsp_valid = (state_q == RESP) ? (NREQ'(1) << owner_q) : '0;
  assign rsp_p     = p_q;
  assign busy      = state_q != IDLE;
  assign op_count  = cnt_q;
endmodule
